router_pkt_tx: RTL

Upstream packet source for the 1x3 router top. It accepts a command (destination, length) and a payload byte stream from a host, buffers the full payload, and then serialises header, payload and parity onto the router input (pkt_valid / data_in), honouring router busy. After the packet, it monitors router error for a fixed window and reports a per-packet status.

---
 rtl/router_pkt_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a host payload, then serialises header/payload/parity to the router and reports the error status.
// Optional feature macro ERR_INJECT_EN adds inject_err, which flips parity bit 0 of the commanded packet.
module router_pkt_tx #(
    parameter int DEPTH    = 64,
    parameter int ERR_WAIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
`ifdef ERR_INJECT_EN
    input  logic       inject_err,
`endif
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    input  logic       error,
    output logic       pkt_valid,
    output logic [7:0] pkt_data,
    output logic       done,
    output logic       status_err,
    output logic       bad_cmd
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, HDR, PAY, PAR, CHK} state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, count;
    logic [7:0]  mem_q [DEPTH];
    logic [1:0]  addr_q, addr_d;
    logic [5:0]  len_q, len_d, rem_q, rem_d;
    logic [7:0]  par_q, par_d, data_q, data_d;
    logic        vld_q, vld_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sticky_q, sticky_d, done_q, done_d, stat_q, stat_d;
    logic        bad_q, bad_d, inj_q, inj_d;
    logic        push, cmd_fire, cmd_bad, inj_in;
    logic [7:0]  hdr, rd_byte;

`ifdef ERR_INJECT_EN
    assign inj_in = inject_err;
`else
    assign inj_in = 1'b0;
`endif

    assign count      = wr_q - rd_q;
    assign pl_ready   = resetn && (count != (AW+1)'(DEPTH));
    assign push       = pl_valid && pl_ready;
    assign cmd_ready  = resetn && (state_q == IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_bad    = (cmd_addr == 2'd3) || (cmd_len == 6'd0);
    assign hdr        = {len_q, addr_q};
    assign rd_byte    = mem_q[rd_q[AW-1:0]];

    assign pkt_valid  = vld_q;
    assign pkt_data   = data_q;
    assign done       = done_q;
    assign status_err = stat_q;
    assign bad_cmd    = bad_q;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        len_d    = len_q;
        rem_d    = rem_q;
        par_d    = par_q;
        data_d   = data_q;
        vld_d    = vld_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        inj_d    = inj_q;
        done_d   = 1'b0;
        stat_d   = 1'b0;
        bad_d    = 1'b0;
        if (push) wr_d = wr_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        bad_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        inj_d   = inj_in;
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (count >= {{(AW-5){1'b0}}, len_q}) begin
                    data_d  = hdr;
                    vld_d   = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!busy) begin
                    par_d   = hdr;
                    data_d  = rd_byte;
                    rd_d    = rd_q + 1'b1;
                    rem_d   = len_q;
                    state_d = PAY;
                end
            end
            PAY: begin
                if (!busy) begin
                    par_d = par_q ^ data_q;
                    rem_d = rem_q - 6'd1;
                    // Last byte: swap straight to the (optionally corrupted) parity.
                    if (rem_q == 6'd1) begin
                        vld_d   = 1'b0;
                        data_d  = par_q ^ data_q ^ {7'd0, inj_q};
                        state_d = PAR;
                    end else begin
                        data_d = rd_byte;
                        rd_d   = rd_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (!busy) begin
                    cnt_d    = 4'(ERR_WAIT);
                    sticky_d = 1'b0;
                    state_d  = CHK;
                end
            end
            CHK: begin
                sticky_d = sticky_q | error;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done_d  = 1'b1;
                    stat_d  = sticky_q | error;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            par_q    <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            inj_q    <= 1'b0;
            done_q   <= 1'b0;
            stat_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            par_q    <= par_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            inj_q    <= inj_d;
            done_q   <= done_d;
            stat_q   <= stat_d;
            bad_q    <= bad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= pl_data;
    end
endmodule
